// File: rtl/fc_score_engine.sv
// FC2 class-score engine: one signed MAC every 3 cycles, requantized scores written to the score RAM.
// Optional FC_ROUND_EN selects round-half-up requantization instead of floor.
module fc_score_engine #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 10,
  parameter int SHIFT = 7,
  parameter int W_AW  = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [9:0]      in_addr,
  input  logic [7:0]      in_data,
  output logic [W_AW-1:0] w_addr,
  input  logic [7:0]      w_data,
  output logic            wr_en,
  output logic [9:0]      wr_addr,
  output logic [7:0]      wr_data,
  output logic            done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ACC    = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam logic [9:0] LAST_I = 10'(N_IN - 1);
  localparam logic [9:0] LAST_J = 10'(N_OUT - 1);

  logic [2:0]        state_q, state_d;
  logic [9:0]        i_q, i_d;
  logic [9:0]        j_q, j_d;
  logic [W_AW-1:0]   wcnt_q, wcnt_d;
  logic [9:0]        in_addr_q, in_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic              done_q, done_d;
  logic signed [23:0] acc_q, acc_d;

  logic signed [16:0] prod;
  logic signed [23:0] rnd;
  logic signed [23:0] shifted;
  logic [7:0]         score;

  // Activation is unsigned, so it gets a zero sign bit before the signed multiply.
  assign prod = $signed({8'b0, in_data}) * $signed({{9{w_data[7]}}, w_data});

`ifdef FC_ROUND_EN
  localparam logic signed [23:0] RND_BIAS = 24'(1) << (SHIFT - 1);
  assign rnd = acc_q + RND_BIAS;
`else
  assign rnd = acc_q;
`endif

  assign shifted = rnd >>> SHIFT;

  always_comb begin
    if (shifted[23])
      score = 8'd0;
    else if (shifted[22:8] != '0)
      score = 8'hFF;
    else
      score = shifted[7:0];
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    wcnt_d    = wcnt_q;
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    done_d    = done_q;
    acc_d     = acc_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          j_d      = '0;
          w_addr_d = '0;
          wcnt_d   = '0;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        acc_d   = '0;
        i_d     = '0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        in_addr_d = i_q;
        w_addr_d  = wcnt_q;
        state_d   = S_WAIT;
      end
      S_WAIT: state_d = S_ACC;
      S_ACC: begin
        // The weight counter runs across row boundaries, giving j*N_IN+i without a multiplier.
        acc_d  = acc_q + {{7{prod[16]}}, prod};
        wcnt_d = wcnt_q + W_AW'(1);
        if (i_q == LAST_I) begin
          state_d = S_WRITE;
        end else begin
          i_d     = i_q + 10'd1;
          state_d = S_ADDR;
        end
      end
      S_WRITE: begin
        if (j_q == LAST_J) begin
          state_d = S_FINISH;
        end else begin
          j_d     = j_q + 10'd1;
          state_d = S_INIT;
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      wcnt_q    <= '0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      done_q    <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      wcnt_q    <= wcnt_d;
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
    end
  end

  assign in_addr = in_addr_q;
  assign w_addr  = w_addr_q;
  assign done    = done_q;
  assign wr_en   = (state_q == S_WRITE);
  assign wr_addr = wr_en ? j_q : '0;
  assign wr_data = wr_en ? score : '0;

endmodule

// File: tb/tb_fc_score_engine.sv
// Self-checking bench for fc_score_engine: random and directed weight/activation sets
// compared cycle by cycle against a dot-product/requantize reference model.
module tb_fc_score_engine;

  localparam int N_IN  = 32;
  localparam int N_OUT = 10;
  localparam int SHIFT = 7;
  localparam int W_AW  = 9;
  localparam int P     = 3 * N_IN + 2;

  logic            clk;
  logic            rst;
  logic            start;
  logic [9:0]      inAddr;
  logic [7:0]      inData;
  logic [W_AW-1:0] wAddr;
  logic [7:0]      wData;
  logic            wrEn;
  logic [9:0]      wrAddr;
  logic [7:0]      wrData;
  logic            done;

  logic [7:0]        actMem [0:1023];
  logic signed [7:0] wtMem  [0:511];
  int                expScore [N_OUT];
  logic [7:0]        scoreRam [0:N_OUT-1];

  int passCnt  = 0;
  int totalCnt = 0;
  int edgeCnt  = 0;
  int runStart = 0;
  int wrCount  = 0;
  int firstDone = -1;
  int cycD;
  bit runHold = 0;
  bit modelActive = 0;
  bit cmpEnable = 0;
  bit expWr;
  bit expDone;

  fc_score_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SHIFT), .W_AW(W_AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_addr(inAddr), .in_data(inData),
    .w_addr(wAddr), .w_data(wData),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Synchronous-read activation RAM and weight ROM
  always @(posedge clk) begin
    inData <= actMem[inAddr];
    wData  <= wtMem[wAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    totalCnt++;
    if (got !== want)
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, got, want, edgeCnt);
    else
      passCnt++;
  endtask

  // Reference: plain integer dot products, shift (with optional rounding), clamp to 0..255
  function automatic void computeExpected();
    for (int j = 0; j < N_OUT; j++) begin
      longint s = 0;
      for (int i = 0; i < N_IN; i++)
        s += longint'(actMem[i]) * longint'(wtMem[j * N_IN + i]);
`ifdef FC_ROUND_EN
      s += longint'(1) << (SHIFT - 1);
`endif
      s = s >>> SHIFT;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      expScore[j] = int'(s);
    end
  endfunction

  task automatic loadPattern(input int kind, input int actMax);
    for (int a = 0; a < 1024; a++) actMem[a] = 8'd0;
    for (int a = 0; a < 512; a++) wtMem[a] = 8'sd0;
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        case (kind)
          0: begin actMem[i] = 8'd8;   wtMem[j * N_IN + i] = 8'(j + 1); end
          1: begin actMem[i] = 8'd255; wtMem[j * N_IN + i] = 8'sd127;   end
          2: begin actMem[i] = 8'($urandom_range(0, 255)); wtMem[j * N_IN + i] = -8'sd1; end
          3: begin actMem[i] = (i == 0) ? 8'd1 : 8'd0; wtMem[j * N_IN + i] = (i == 0) ? 8'sd64 : 8'sd0; end
          default: begin
            actMem[i] = 8'($urandom_range(0, actMax));
            wtMem[j * N_IN + i] = 8'($urandom_range(0, 255));
          end
        endcase
      end
    end
    computeExpected();
  endtask

  task automatic waitUntil(input int target);
    do begin
      @(posedge clk);
      #1;
    end while (edgeCnt < target);
  endtask

  // Cycle-level compare: writes land at cycles (j+1)*P after the start edge, done after the last one
  always @(negedge clk) begin
    if (cmpEnable) begin
      if (wrEn === 1'b1 && wrAddr < N_OUT) begin
        scoreRam[wrAddr] = wrData;
        wrCount++;
      end
      if (modelActive) begin
        cycD  = edgeCnt - runStart + 1;
        expWr = (cycD % P == 0) && (cycD / P >= 1) && (cycD / P <= N_OUT);
        checkOutput("wr_en", wrEn, expWr);
        if (expWr) begin
          checkOutput("wr_addr", wrAddr, cycD / P - 1);
          checkOutput("wr_data", wrData, expScore[cycD / P - 1]);
        end
        expDone = (cycD == N_OUT * P + 2) || (runHold && cycD > N_OUT * P + 2);
        checkOutput("done", done, expDone);
        if (done === 1'b1 && firstDone < 0) firstDone = edgeCnt - runStart;
      end else begin
        checkOutput("wr_en_idle", wrEn, 0);
      end
    end
  end

  task automatic applyStimulus(input bit holdStart, input int pulseAt, input int rstAt);
    waitUntil(edgeCnt + 1);
    start       = 1'b1;
    runStart    = edgeCnt + 1;
    runHold     = holdStart;
    wrCount     = 0;
    firstDone   = -1;
    modelActive = 1'b1;
    if (!holdStart) begin
      waitUntil(runStart);
      start = 1'b0;
    end
    if (pulseAt > 0) begin
      waitUntil(runStart + pulseAt - 1);
      start = 1'b1;
      waitUntil(runStart + pulseAt);
      start = 1'b0;
    end
    if (rstAt > 0) begin
      waitUntil(runStart + rstAt - 1);
      rst = 1'b1;
      start = 1'b0;
      modelActive = 1'b0;
      waitUntil(runStart + rstAt);
      checkOutput("rst_wr_en", wrEn, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_in_addr", inAddr, 0);
      checkOutput("rst_w_addr", wAddr, 0);
      checkOutput("rst_wr_data", wrData, 0);
      checkOutput("rst_writes_before", wrCount, (rstAt - 1) / P);
      rst = 1'b0;
      return;
    end
    waitUntil(runStart + N_OUT * P + 3);
    checkOutput("write_count", wrCount, N_OUT);
    checkOutput("done_edge", firstDone, N_OUT * P + 1);
    if (holdStart) begin
      checkOutput("done_held", done, 1);
      waitUntil(edgeCnt + 5);
      modelActive = 1'b0;
      start = 1'b0;
      waitUntil(edgeCnt + 2);
      checkOutput("done_cleared", done, 0);
    end else begin
      modelActive = 1'b0;
      checkOutput("done_pulse_cleared", done, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < N_OUT; k++) scoreRam[k] = 8'hAA;
    loadPattern(0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_addr", inAddr, 0);
    checkOutput("reset_w_addr", wAddr, 0);
    checkOutput("reset_wr_en", wrEn, 0);
    checkOutput("reset_wr_addr", wrAddr, 0);
    checkOutput("reset_wr_data", wrData, 0);
    checkOutput("reset_done", done, 0);
    rst = 1'b0;
    cmpEnable = 1'b1;

    // Row j weights j+1, activations 8: scores 2,4,...,20
    applyStimulus(1, 0, 0);
    checkOutput("ramp_addr0", scoreRam[0], 2);
    checkOutput("ramp_addr5", scoreRam[5], 12);
    checkOutput("ramp_addr9", scoreRam[9], 20);
    checkOutput("ramp_done_edge", firstDone, 981);
    applyStimulus(1, 0, 0);
    checkOutput("rerun_addr9", scoreRam[9], 20);

    loadPattern(1, 0);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < N_OUT; k++) checkOutput("sat_high", scoreRam[k], 255);

    loadPattern(2, 0);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < N_OUT; k++) checkOutput("sat_low", scoreRam[k], 0);

    loadPattern(3, 0);
    applyStimulus(0, 0, 0);
`ifdef FC_ROUND_EN
    checkOutput("round_half", scoreRam[0], 1);
`else
    checkOutput("round_half", scoreRam[0], 0);
`endif

    loadPattern(4, 255);
    applyStimulus(0, 100, 0);

    loadPattern(4, 31);
    applyStimulus(1, 0, 500);
    applyStimulus(0, 0, 0);

    for (int r = 0; r < 3; r++) begin
      loadPattern(4, $urandom_range(3, 63));
      applyStimulus(0, 0, 0);
    end

    cmpEnable = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
